r_response_memory: RTL and testbench
====================================

Name: r_response_memory

Overview:
- Holds out-of-order read-response beats parked by the ordering unit until their turn comes.
- Sits directly downstream of the ordering unit's store path and feeds its release path.
- Keyed by unique ID {row,col}; each UID owns a private slot of up to MAX_LEN beats.
- Beats of a UID are released in arrival order on request.

Parameters:
- ID_WIDTH, 32, width of the UID field on both interfaces.
- DATA_WIDTH, 64, beat data width. Must match the r_if instance.
- RESP_WIDTH, 2, response code width.
- MAX_OUTSTANDING, 16, number of rows and number of columns. UID = {row[ROW_W-1:0], col[COL_W-1:0]}, where ROW_W = COL_W = $clog2(MAX_OUTSTANDING).
- MAX_LEN, 8, maximum beats per UID slot.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- r_store  r_if.receiver  bundle  beats to park: id = UID, data, resp, last. valid in, ready out.
- release_uid  input  ID_WIDTH  UID whose next beat is presented on r_release.
- r_release  r_if.sender  bundle  parked beat for release_uid: id, data, resp, last. valid out, ready in (ready = release request).
- beats_stored  output  $clog2(MAX_OUTSTANDING*MAX_OUTSTANDING*MAX_LEN+1)  total beats currently held.
- err_overflow  output  1  sticky flag: a store was refused because a slot was full without last.

Behaviour:
- UID decode: only the low ROW_W+COL_W bits are used; upper bits are ignored.
- Storage: beat array mem[slot][beat], with slot = MAX_OUTSTANDING² and beat = MAX_LEN. Each entry holds data, resp, last. Storage is not reset.
- Per-slot state: wr_cnt and rd_cnt (0..MAX_LEN, $clog2(MAX_LEN+1) bits each) and a closed flag, set when a beat with last=1 is stored.
- Reset (rst=0, async): all wr_cnt, rd_cnt, closed and err_overflow cleared; beats_stored=0. r_release.valid=0 and r_store.ready=0 while rst is low.
- Store handshake, on r_store.valid & r_store.ready:
  - ready = ~closed[s] & (wr_cnt[s] < MAX_LEN), with s = UID slot; combinational from registered state only.
  - Write beat at mem[s][wr_cnt[s]]; wr_cnt[s]++.
  - If last=1, set closed[s].
- Ready-low cases:
  - closed slot: the UID is being reused before it has drained; ready stays 0 until the slot clears.
  - full slot without last: ready=0 and err_overflow sets (remains 1 until reset).
- Release:
  - r_release.valid = rd_cnt[t] < wr_cnt[t], with t = release_uid slot.
  - Outputs come combinationally from mem[t][rd_cnt[t]]: data, resp, last. id = release_uid.
  - Zero-latency read of registered contents. A beat stored in cycle N is releasable in cycle N+1 at the earliest; there is no same-cycle store-to-release bypass.
- Release handshake, on valid & ready:
  - rd_cnt[t]++.
  - If the beat had last=1: clear wr_cnt[t], rd_cnt[t] and closed[t] at the clock edge, freeing the slot for reuse the next cycle.
- release_uid may change in any cycle, including while valid=1 and ready=0. Valid and data follow the new UID immediately; no state is altered without a handshake.
- Simultaneous store and release:
  - Different slots: fully independent.
  - Same slot: the write goes to index wr_cnt and the read to index rd_cnt, and both counters update in the same cycle.
  - Same slot and the released beat is last: the slot must already be closed, so the store cannot be accepted; there is no conflict.
- beats_stored: +1 on a store handshake, −1 on a release handshake, net 0 when both occur. Never wraps.
- No stored beat is ever dropped or duplicated. Release order within a slot equals store order.

Test Plan:
- Reset then idle, rst low for 3 cycles -> r_release.valid=0, r_store.ready=0 during reset; after reset store ready=1, beats_stored=0, err_overflow=0.
- Store UID 0x23 beats D0, D1, D2 (last on D2), then release_uid=0x23 with ready=1 -> D0, D1, D2 out in consecutive cycles, last only on D2. beats_stored goes 3→0. Next cycle the slot accepts a new burst.
- Store UID 0x05 with 8 beats and no last, then offer a 9th -> ready=0 on the 9th, err_overflow=1 sticky, beats_stored=8.
- Store to closed UID 0x10 (last stored, not yet drained) -> ready=0. Release its final beat -> ready=1 the following cycle.
- Interleave: store beats for UIDs 0x00 and 0x11 alternately while releasing 0x00 in the same cycles -> per-UID order preserved, counts consistent. Same-slot store+release cycle leaves wr_cnt−rd_cnt unchanged.
- Switch release_uid between 0x11 and 0x00 while ready=0 -> valid and data track the selected UID; no counter changes. Store in cycle N is visible to release at N+1, not N.

Source files
------------

// File: rtl/r_response_memory.sv
// Read-response parking memory.
// Out-of-order read beats are parked per UID slot by the ordering unit and
// handed back, in arrival order, when the release side asks for that UID.
// Each slot is a small FIFO. A write counter and a read counter index into the
// slot's beat array. A 'closed' flag blocks reuse of the UID until the last
// beat has been released.
module r_response_memory #(
  parameter int unsigned ID_WIDTH        = 32,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned RESP_WIDTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned MAX_LEN         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // Store side (beats to park)
  input  logic                  r_store_valid,
  output logic                  r_store_ready,
  input  logic [ID_WIDTH-1:0]   r_store_id,
  input  logic [DATA_WIDTH-1:0] r_store_data,
  input  logic [RESP_WIDTH-1:0] r_store_resp,
  input  logic                  r_store_last,
  // Release side (ready doubles as the release request)
  input  logic [ID_WIDTH-1:0]   release_uid,
  output logic                  r_release_valid,
  input  logic                  r_release_ready,
  output logic [ID_WIDTH-1:0]   r_release_id,
  output logic [DATA_WIDTH-1:0] r_release_data,
  output logic [RESP_WIDTH-1:0] r_release_resp,
  output logic                  r_release_last,
  // Status
  output logic [$clog2(MAX_OUTSTANDING*MAX_OUTSTANDING*MAX_LEN+1)-1:0] beats_stored,
  output logic                  err_overflow
);

  localparam int unsigned RowW     = $clog2(MAX_OUTSTANDING);
  localparam int unsigned SlotW    = 2 * RowW;
  // Slots are addressed by the concatenated {row,col} bits, so the row/col
  // count is expected to be a power of two.
  localparam int unsigned NumSlots = MAX_OUTSTANDING * MAX_OUTSTANDING;
  localparam int unsigned BeatW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned CntW     = $clog2(MAX_LEN + 1);
  localparam int unsigned TotW     = $clog2(MAX_OUTSTANDING * MAX_OUTSTANDING * MAX_LEN + 1);

  localparam logic [CntW-1:0] MaxLenCnt = CntW'(MAX_LEN);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;
  } beat_t;

  // Beat storage, intentionally without reset
  beat_t mem_q [NumSlots][MAX_LEN];

  // Per-slot bookkeeping
  logic [CntW-1:0] wr_cnt_q [NumSlots];
  logic [CntW-1:0] wr_cnt_d [NumSlots];
  logic [CntW-1:0] rd_cnt_q [NumSlots];
  logic [CntW-1:0] rd_cnt_d [NumSlots];
  logic            closed_q [NumSlots];
  logic            closed_d [NumSlots];

  logic [TotW-1:0] beats_q, beats_d;
  logic            err_q, err_d;

  logic [SlotW-1:0] store_slot;
  logic [SlotW-1:0] rel_slot;
  logic [CntW-1:0]  store_wr;
  logic [CntW-1:0]  rel_rd;
  logic [CntW-1:0]  rel_wr;
  logic             store_closed;
  logic             store_hs;
  logic             rel_hs;
  logic             store_overflow;
  beat_t            rel_beat;
  beat_t            store_beat;

  // Only the low {row,col} bits of the UID select a slot
  logic unused_store_id;
  assign unused_store_id = ^r_store_id;

  // Slot decode and registered-state lookups for both ports
  always_comb begin
    store_slot   = r_store_id[SlotW-1:0];
    rel_slot     = release_uid[SlotW-1:0];
    store_wr     = wr_cnt_q[store_slot];
    store_closed = closed_q[store_slot];
    rel_rd       = rd_cnt_q[rel_slot];
    rel_wr       = wr_cnt_q[rel_slot];
    rel_beat     = mem_q[rel_slot][rel_rd[BeatW-1:0]];
    store_beat   = '{data: r_store_data, resp: r_store_resp, last: r_store_last};
  end

  // Handshakes and port outputs; both ports are held idle while in reset
  always_comb begin
    r_store_ready   = rst & ~store_closed & (store_wr < MaxLenCnt);
    r_release_valid = rst & (rel_rd < rel_wr);
    r_release_id    = release_uid;
    r_release_data  = rel_beat.data;
    r_release_resp  = rel_beat.resp;
    r_release_last  = rel_beat.last;
    store_hs        = r_store_valid & r_store_ready;
    rel_hs          = r_release_valid & r_release_ready;
    // Full slot with no last beat: the burst is longer than a slot can hold
    store_overflow  = rst & r_store_valid & ~store_closed & (store_wr >= MaxLenCnt);
    beats_stored    = beats_q;
    err_overflow    = err_q;
  end

  // Next-state for counters, closed flags, occupancy and the sticky error
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    closed_d = closed_q;
    beats_d  = beats_q;
    err_d    = err_q | store_overflow;

    if (store_hs) begin
      wr_cnt_d[store_slot] = store_wr + CntW'(1);
      if (r_store_last) begin
        closed_d[store_slot] = 1'b1;
      end
    end

    // A same-slot store can never coincide with the last release: the slot is
    // closed then, so the store is refused and the clear below cannot race it.
    if (rel_hs) begin
      rd_cnt_d[rel_slot] = rel_rd + CntW'(1);
      if (rel_beat.last) begin
        wr_cnt_d[rel_slot] = '0;
        rd_cnt_d[rel_slot] = '0;
        closed_d[rel_slot] = 1'b0;
      end
    end

    unique case ({store_hs, rel_hs})
      2'b10:   beats_d = beats_q + TotW'(1);
      2'b01:   beats_d = beats_q - TotW'(1);
      default: beats_d = beats_q;
    endcase
  end

  // Bookkeeping state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NumSlots; i++) begin
        wr_cnt_q[i] <= '0;
        rd_cnt_q[i] <= '0;
        closed_q[i] <= 1'b0;
      end
      beats_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        wr_cnt_q[i] <= wr_cnt_d[i];
        rd_cnt_q[i] <= rd_cnt_d[i];
        closed_q[i] <= closed_d[i];
      end
      beats_q <= beats_d;
      err_q   <= err_d;
    end
  end

  // Beat write port; a new beat is readable from the following cycle
  always_ff @(posedge clk) begin
    if (store_hs) begin
      mem_q[store_slot][store_wr[BeatW-1:0]] <= store_beat;
    end
  end

endmodule

// File: tb/tb_r_response_memory.sv
// Self-checking bench for r_response_memory: scoreboard of parked beats,
// one task per scenario with inline comparisons.
module tb_r_response_memory;

  localparam int IDW  = 32;
  localparam int DW   = 64;
  localparam int RW   = 2;
  localparam int MO   = 16;
  localparam int ML   = 8;
  localparam int BSW  = $clog2(MO * MO * ML + 1);
  localparam int RelW = 1 + IDW + DW + RW + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           r_store_valid = 1'b0;
  logic           r_store_ready;
  logic [IDW-1:0] r_store_id = '0;
  logic [DW-1:0]  r_store_data = '0;
  logic [RW-1:0]  r_store_resp = '0;
  logic           r_store_last = 1'b0;
  logic [IDW-1:0] release_uid = '0;
  logic           r_release_valid;
  logic           r_release_ready = 1'b0;
  logic [IDW-1:0] r_release_id;
  logic [DW-1:0]  r_release_data;
  logic [RW-1:0]  r_release_resp;
  logic           r_release_last;
  logic [BSW-1:0] beats_stored;
  logic           err_overflow;

  always #5 clk = ~clk;

  r_response_memory #(
    .ID_WIDTH(IDW), .DATA_WIDTH(DW), .RESP_WIDTH(RW), .MAX_OUTSTANDING(MO), .MAX_LEN(ML)
  ) dut (
    .clk(clk), .rst(rst),
    .r_store_valid(r_store_valid), .r_store_ready(r_store_ready), .r_store_id(r_store_id),
    .r_store_data(r_store_data), .r_store_resp(r_store_resp), .r_store_last(r_store_last),
    .release_uid(release_uid), .r_release_valid(r_release_valid),
    .r_release_ready(r_release_ready), .r_release_id(r_release_id),
    .r_release_data(r_release_data), .r_release_resp(r_release_resp),
    .r_release_last(r_release_last), .beats_stored(beats_stored), .err_overflow(err_overflow)
  );

  typedef struct packed {
    logic [7:0]    slot;
    logic [DW-1:0] data;
    logic [RW-1:0] resp;
    logic          last;
  } sb_t;

  sb_t sb_q[$];
  int  m_wr [256];
  int  m_rd [256];
  bit  m_closed [256];
  int  m_beats = 0;
  bit  m_err = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  function automatic int sb_find(logic [7:0] s);
    foreach (sb_q[i]) if (sb_q[i].slot == s) return i;
    return -1;
  endfunction

  function automatic bit m_ready(logic [IDW-1:0] uid);
    logic [7:0] s = uid[7:0];
    return rst && !m_closed[s] && (m_wr[s] < ML);
  endfunction

  function automatic logic [RelW-1:0] exp_rel();
    int idx = sb_find(release_uid[7:0]);
    if (!rst || idx < 0) return {1'b0, release_uid, {(DW + RW + 1){1'b0}}};
    return {1'b1, release_uid, sb_q[idx].data, sb_q[idx].resp, sb_q[idx].last};
  endfunction

  function automatic logic [RelW-1:0] obs_rel();
    return {r_release_valid, r_release_id,
            r_release_valid ? {r_release_data, r_release_resp, r_release_last}
                            : {(DW + RW + 1){1'b0}}};
  endfunction

  task automatic set_store(input bit v, input logic [IDW-1:0] uid, input bit last);
    r_store_valid = v;
    r_store_id    = uid;
    r_store_data  = {$urandom, $urandom};
    r_store_resp  = 2'($urandom);
    r_store_last  = last;
  endtask

  task automatic set_rel(input logic [IDW-1:0] uid, input bit rdy);
    release_uid     = uid;
    r_release_ready = rdy;
  endtask

  // Advance one clock and apply the accepted handshakes to the scoreboard
  task automatic tick();
    bit st, rl, ovf;
    int idx;
    logic [7:0] s, t;
    sb_t e;
    @(posedge clk);
    s   = r_store_id[7:0];
    t   = release_uid[7:0];
    st  = r_store_valid && m_ready(r_store_id);
    ovf = r_store_valid && rst && !m_closed[s] && (m_wr[s] >= ML);
    idx = sb_find(t);
    rl  = r_release_ready && rst && (idx >= 0);
    if (ovf) m_err = 1'b1;
    if (rl) begin
      e = sb_q[idx];
      sb_q.delete(idx);
      m_rd[t]++;
      m_beats--;
      if (e.last) begin
        m_wr[t] = 0;
        m_rd[t] = 0;
        m_closed[t] = 1'b0;
      end
    end
    if (st) begin
      sb_q.push_back('{slot: s, data: r_store_data, resp: r_store_resp, last: r_store_last});
      m_wr[s]++;
      if (r_store_last) m_closed[s] = 1'b1;
      m_beats++;
    end
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    set_rel(32'h23, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (r_store_ready !== 1'b0 || r_release_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle cyc%0d: ready=%b valid=%b, want 0/0", i, r_store_ready,
                 r_release_valid);
      end
      tick();
    end
    rst = 1'b1;
    set_rel(32'h23, 1'b0);
    set_store(1'b0, 32'h23, 1'b0);
    #1;
    tests_run++;
    if ({r_store_ready, beats_stored, err_overflow} !== {1'b1, BSW'(0), 1'b0}) begin
      tests_failed++;
      $display("FAIL after_reset: ready=%b beats=%0d err=%b, want 1/0/0", r_store_ready,
               beats_stored, err_overflow);
    end
    tick();
  endtask

  task automatic test_basic_burst();
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 32'hFFFF_FF23, i == 2);  // upper UID bits must be ignored
      set_rel(32'h23, 1'b0);
      #1;
      tests_run++;
      if (r_store_ready !== m_ready(r_store_id)) begin
        tests_failed++;
        $display("FAIL burst_store_ready beat%0d: got %b want %b", i, r_store_ready,
                 m_ready(r_store_id));
      end
      tests_run++;
      if (obs_rel() !== exp_rel()) begin
        tests_failed++;
        $display("FAIL burst_peek beat%0d: got %h want %h", i, obs_rel(), exp_rel());
      end
      tick();
    end
    set_store(1'b0, 32'h23, 1'b0);
    tests_run++;
    if (beats_stored !== BSW'(3)) begin
      tests_failed++;
      $display("FAIL burst_count_full: got %0d want 3", beats_stored);
    end
    for (int i = 0; i < 3; i++) begin
      set_rel(32'h23, 1'b1);
      #1;
      tests_run++;
      if (obs_rel() !== exp_rel() || r_release_last !== (i == 2)) begin
        tests_failed++;
        $display("FAIL burst_release beat%0d: got %h want %h", i, obs_rel(), exp_rel());
      end
      tick();
      tests_run++;
      if (beats_stored !== BSW'(m_beats)) begin
        tests_failed++;
        $display("FAIL burst_count beat%0d: got %0d want %0d", i, beats_stored, m_beats);
      end
    end
    // Slot is free again right after the last beat left
    set_store(1'b1, 32'h23, 1'b1);
    set_rel(32'h23, 1'b0);
    #1;
    tests_run++;
    if (r_store_ready !== 1'b1 || r_release_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL burst_reuse: ready=%b valid=%b want 1/0", r_store_ready, r_release_valid);
    end
    tick();
    set_store(1'b0, 32'h23, 1'b0);
    set_rel(32'h23, 1'b1);
    #1;
    tests_run++;
    if (obs_rel() !== exp_rel()) begin
      tests_failed++;
      $display("FAIL burst_reuse_release: got %h want %h", obs_rel(), exp_rel());
    end
    tick();
  endtask

  task automatic test_closed();
    for (int i = 0; i < 2; i++) begin
      set_store(1'b1, 32'h10, i == 1);
      set_rel(32'h10, 1'b0);
      tick();
    end
    set_store(1'b1, 32'h10, 1'b1);
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if (r_store_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL closed_ready cyc%0d: got %b want 0", i, r_store_ready);
      end
      tick();
    end
    tests_run++;
    if (err_overflow !== m_err) begin
      tests_failed++;
      $display("FAIL closed_no_err: got %b want %b", err_overflow, m_err);
    end
    set_rel(32'h10, 1'b1);
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if (obs_rel() !== exp_rel() || r_store_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL closed_drain beat%0d: rel=%h want %h ready=%b want 0", i, obs_rel(),
                 exp_rel(), r_store_ready);
      end
      tick();
    end
    set_rel(32'h10, 1'b0);
    #1;
    tests_run++;
    if (r_store_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL closed_reopen: ready got %b want 1", r_store_ready);
    end
    tick();
    set_store(1'b0, 32'h10, 1'b0);
    set_rel(32'h10, 1'b1);
    tick();
    set_rel(32'h10, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < ML + 1; i++) begin
      set_store(1'b1, 32'h05, 1'b0);
      #1;
      tests_run++;
      if (r_store_ready !== (i < ML)) begin
        tests_failed++;
        $display("FAIL ovf_ready beat%0d: got %b want %b", i, r_store_ready, i < ML);
      end
      tick();
    end
    set_store(1'b0, 32'h05, 1'b0);
    tests_run++;
    if ({err_overflow, beats_stored} !== {m_err, BSW'(m_beats)} || !m_err) begin
      tests_failed++;
      $display("FAIL ovf_flag: err=%b beats=%0d want %b/%0d", err_overflow, beats_stored,
               m_err, m_beats);
    end
    tick();
    tick();
    tests_run++;
    if (err_overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_sticky: got %b want 1", err_overflow);
    end
  endtask

  task automatic test_interleave();
    for (int i = 0; i < 2; i++) begin
      set_store(1'b1, 32'h00, 1'b0);
      set_rel(32'h00, 1'b0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      set_store(1'b1, (i % 2 == 0) ? 32'h00 : 32'h11, i >= 6);
      set_rel(32'h00, 1'b1);
      #1;
      tests_run++;
      if (r_store_ready !== m_ready(r_store_id)) begin
        tests_failed++;
        $display("FAIL ilv_ready cyc%0d: got %b want %b", i, r_store_ready,
                 m_ready(r_store_id));
      end
      tests_run++;
      if (obs_rel() !== exp_rel()) begin
        tests_failed++;
        $display("FAIL ilv_release cyc%0d: got %h want %h", i, obs_rel(), exp_rel());
      end
      tick();
      tests_run++;
      if (beats_stored !== BSW'(m_beats)) begin
        tests_failed++;
        $display("FAIL ilv_count cyc%0d: got %0d want %0d", i, beats_stored, m_beats);
      end
    end
    set_store(1'b0, 32'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (obs_rel() !== exp_rel()) begin
        tests_failed++;
        $display("FAIL ilv_drain cyc%0d: got %h want %h", i, obs_rel(), exp_rel());
      end
      tick();
    end
  endtask

  task automatic test_switch();
    logic [BSW-1:0] held;
    set_store(1'b1, 32'h00, 1'b1);
    set_rel(32'h00, 1'b0);
    #1;
    tests_run++;
    if (r_release_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_bypass: valid got %b want 0", r_release_valid);
    end
    tick();
    set_store(1'b0, 32'h00, 1'b0);
    held = BSW'(m_beats);
    for (int i = 0; i < 6; i++) begin
      set_rel((i % 2 == 1) ? 32'h11 : 32'h00, 1'b0);
      #1;
      tests_run++;
      if (obs_rel() !== exp_rel() || !r_release_valid) begin
        tests_failed++;
        $display("FAIL switch_view cyc%0d: got %h want %h", i, obs_rel(), exp_rel());
      end
      tick();
      tests_run++;
      if (beats_stored !== held) begin
        tests_failed++;
        $display("FAIL switch_count cyc%0d: got %0d want %0d", i, beats_stored, held);
      end
    end
    for (int i = 0; i < 6; i++) begin
      set_rel((i == 0 || i == 5) ? 32'h00 : 32'h11, 1'b1);
      #1;
      tests_run++;
      if (obs_rel() !== exp_rel()) begin
        tests_failed++;
        $display("FAIL switch_drain cyc%0d: got %h want %h", i, obs_rel(), exp_rel());
      end
      tick();
    end
    set_rel(32'h00, 1'b0);
    tests_run++;
    if (beats_stored !== BSW'(m_beats) || sb_q.size() != ML) begin
      tests_failed++;
      $display("FAIL final_count: got %0d want %0d (sb %0d)", beats_stored, m_beats,
               sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_closed();
    test_overflow();
    test_interleave();
    test_switch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
